// File: rtl/ram8_gate.sv
// ram8_gate: eight 16-bit words with a single-cycle write and an asynchronous clear.
// The read port is purely combinational through mux8way16_gate, selected by the same address as the write.

module mux8way16_gate (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  input  logic [15:0] d_i,
  input  logic [15:0] e_i,
  input  logic [15:0] f_i,
  input  logic [15:0] g_i,
  input  logic [15:0] h_i,
  input  logic [2:0]  sel_i,
  output logic [15:0] out_o
);

  logic [15:0] lvl0_ab;
  logic [15:0] lvl0_cd;
  logic [15:0] lvl0_ef;
  logic [15:0] lvl0_gh;
  logic [15:0] lvl1_lo;
  logic [15:0] lvl1_hi;

  // Binary tree of 2-way muxes: sel_i[0] picks within pairs, sel_i[2] picks the half.
  assign lvl0_ab = sel_i[0] ? b_i : a_i;
  assign lvl0_cd = sel_i[0] ? d_i : c_i;
  assign lvl0_ef = sel_i[0] ? f_i : e_i;
  assign lvl0_gh = sel_i[0] ? h_i : g_i;

  assign lvl1_lo = sel_i[1] ? lvl0_cd : lvl0_ab;
  assign lvl1_hi = sel_i[1] ? lvl0_gh : lvl0_ef;

  assign out_o   = sel_i[2] ? lvl1_hi : lvl1_lo;

endmodule

module ram8_gate #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] out
);

  logic [7:0]       load_dec;
  logic [WIDTH-1:0] word_q [8];
  logic [WIDTH-1:0] word_d [8];

  // One-hot write strobe; all zero when load is low.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    load_dec = '0;
    if (load) begin
      load_dec[address] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      word_d[i] = load_dec[i] ? in : word_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these eight words are discrete flops, not a RAM macro, so the asynchronous clear is legitimate.
      for (int i = 0; i < 8; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment so every word updates from pre-edge values.
      for (int i = 0; i < 8; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  mux8way16_gate u_read_mux (
    .a_i   (word_q[0]),
    .b_i   (word_q[1]),
    .c_i   (word_q[2]),
    .d_i   (word_q[3]),
    .e_i   (word_q[4]),
    .f_i   (word_q[5]),
    .g_i   (word_q[6]),
    .h_i   (word_q[7]),
    .sel_i (address),
    .out_o (out)
  );

endmodule

// File: tb/tb_ram8_gate.sv
// Scoreboard bench for ram8_gate: stimulus queues the expected read value, and a negedge monitor compares it.
// The reference is a plain array of words updated at each write edge.

module tb_ram8_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [2:0]  address;
  logic [15:0] in_d;
  logic [15:0] out_d;

  ram8_gate #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_d),
    .load    (load),
    .address (address),
    .out     (out_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    logic [2:0]  addr;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] ref_mem [8];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [2:0] a,
                       input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s addr=%0d got=%h expected=%h at %0t", name, a, act, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, midway between writes.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.name, mon_e.addr, out_d, mon_e.exp);
    end
  end

  task automatic clear_ref();
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0000;
  endtask

  // Called at posedge+1: drive a cycle, optionally expect the pre-edge read, then commit the write.
  task automatic cycle(input logic ld, input logic [2:0] a, input logic [15:0] d,
                       input bit chk, input string name);
    load    = ld;
    address = a;
    in_d    = d;
    if (chk) sb_q.push_back('{exp: ref_mem[a], addr: a, name: name});
    @(posedge clk);
    if (ld) ref_mem[a] = d;
    #1;
  endtask

  task automatic sweep(input string name);
    for (int a = 0; a < 8; a++) cycle(1'b0, 3'(a), 16'h0000, 1'b1, name);
  endtask

  // 3 ns low pulse between edges; the read is expected to show zero while reset is still held.
  task automatic pulse_reset();
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    clear_ref();
    sb_q.push_back('{exp: 16'h0000, addr: address, name: "reset_immediate"});
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    address = 3'd0;
    in_d    = 16'h0000;
    clear_ref();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    sweep("por_clear");

    for (int a = 0; a < 8; a++) cycle(1'b1, 3'(a), 16'hFFFF, 1'b0, "");
    sweep("pre_reset_ffff");
    pulse_reset();
    sweep("reset_clear");

    for (int a = 0; a < 8; a++) cycle(1'b1, 3'(a), 16'(16'h1111 * (a + 1)), 1'b0, "");
    sweep("fill_readback");

    cycle(1'b1, 3'd5, 16'hABCD, 1'b0, "");
    sweep("write_isolation");

    // Pre-edge read must show the old 4444 and the post-edge read the new value.
    cycle(1'b1, 3'd3, 16'h5A5A, 1'b1, "same_cycle_before");
    cycle(1'b0, 3'd3, 16'h0000, 1'b1, "same_cycle_after");

    for (int a = 0; a < 8; a++)
      for (int k = 0; k < 3; k++) cycle(1'b0, 3'(a), 16'hDEAD, 1'b1, "load_gating");
    sweep("load_gating_sweep");

    load    = 1'b1;
    address = 3'd2;
    in_d    = 16'h1234;
    #2;
    rst_n = 1'b0;
    clear_ref();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 3'd2, 16'h0000, 1'b1, "reset_during_write");
    sweep("reset_during_write_sweep");

    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) pulse_reset();
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 1'b1, "random");
    end
    sweep("final_sweep");

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
